// File: rtl/shadow_mem_arbiter.sv
// shadow_mem_arbiter
// Shares one SDRAM client port between the Apple II shadow-write stream and
// the video scanout read stream. Shadow writes are buffered in a small FIFO so
// bus writes never stall; video reads win arbitration unless the write backlog
// has reached HIGH_WATER. Exactly one SDRAM command is outstanding at a time.
//
// Optional build macro: SHADOW_ARB_MERGE_EN
//   When defined, a push whose address matches the newest FIFO entry (and that
//   entry is not the one being issued) merges into it byte-wise instead of
//   allocating a new entry.
//
// Ports:
//   clk_logic, system_reset_n         clock, async active-low reset
//   wr_strobe_i/addr/data/be          one-cycle shadow write request
//   vid_rd_i/vid_addr_i               one-cycle video read request
//   vid_data_o/vid_valid_o            video read data + one-cycle valid pulse
//   mem_rd_o/mem_wr_o/addr/data/be    SDRAM command, held until mem_ack_i
//   mem_ack_i, mem_q_i, mem_rvalid_i  SDRAM accept / read data return
//   fifo_count_o                      current FIFO occupancy
//   overflow_o                        sticky: a shadow write was dropped
module shadow_mem_arbiter #(
  parameter int FIFO_DEPTH = 8,
  parameter int HIGH_WATER = 6,
  parameter int ADDR_WIDTH = 21
) (
  input  logic                          clk_logic,
  input  logic                          system_reset_n,
  input  logic                          wr_strobe_i,
  input  logic [ADDR_WIDTH-1:0]         wr_addr_i,
  input  logic [31:0]                   wr_data_i,
  input  logic [3:0]                    wr_be_i,
  input  logic                          vid_rd_i,
  input  logic [ADDR_WIDTH-1:0]         vid_addr_i,
  output logic [31:0]                   vid_data_o,
  output logic                          vid_valid_o,
  output logic                          mem_rd_o,
  output logic                          mem_wr_o,
  output logic [ADDR_WIDTH-1:0]         mem_addr_o,
  output logic [31:0]                   mem_data_o,
  output logic [3:0]                    mem_be_o,
  input  logic                          mem_ack_i,
  input  logic [31:0]                   mem_q_i,
  input  logic                          mem_rvalid_i,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
  output logic                          overflow_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] HW_C    = CW'(HIGH_WATER);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  typedef enum logic [1:0] {
    IDLE,
    WRITE_CMD,
    READ_CMD,
    READ_WAIT
  } state_t;

  state_t state_q, state_d;

  // FIFO storage and bookkeeping
  logic [ADDR_WIDTH-1:0] fifo_addr [FIFO_DEPTH];
  logic [31:0]           fifo_data [FIFO_DEPTH];
  logic [3:0]            fifo_be   [FIFO_DEPTH];
  logic [PW-1:0]         rd_ptr, wr_ptr;
  logic [CW-1:0]         count_q;

  // Latched video request
  logic                  vid_pend;
  logic [ADDR_WIDTH-1:0] vid_addr_q;

  logic pick_wr, pick_rd;
  logic pop, rd_ack;
  logic merge, alloc;

  assign pop    = (state_q == WRITE_CMD) && mem_ack_i;
  assign rd_ack = (state_q == READ_CMD)  && mem_ack_i;

  // Next-state / arbitration decision
  always_comb begin
    state_d = state_q;
    pick_wr = 1'b0;
    pick_rd = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_q >= HW_C) begin
          pick_wr = 1'b1;
          state_d = WRITE_CMD;
        end else if (vid_pend) begin
          pick_rd = 1'b1;
          state_d = READ_CMD;
        end else if (count_q != '0) begin
          pick_wr = 1'b1;
          state_d = WRITE_CMD;
        end
      end
      WRITE_CMD: if (mem_ack_i)    state_d = IDLE;
      READ_CMD:  if (mem_ack_i)    state_d = READ_WAIT;
      READ_WAIT: if (mem_rvalid_i) state_d = IDLE;
      default:                     state_d = IDLE;
    endcase
  end

`ifdef SHADOW_ARB_MERGE_EN
  logic [PW-1:0] last_ptr;
  logic          head_busy;
  assign last_ptr  = wr_ptr - PW'(1);
  // The head is captured into the command registers when picked and held
  // during WRITE_CMD; when it is also the newest entry it must not be merged.
  assign head_busy = (state_q == WRITE_CMD) || pick_wr;
  assign merge     = wr_strobe_i && (count_q != '0) &&
                     (fifo_addr[last_ptr] == wr_addr_i) &&
                     !((count_q == ONE_C) && head_busy);
`else
  assign merge = 1'b0;
`endif

  // A full FIFO still accepts a push when the head pops in the same cycle.
  assign alloc = wr_strobe_i && !merge && ((count_q != DEPTH_C) || pop);

  // FIFO payload storage (no reset needed; validity is tracked by count_q)
  always_ff @(posedge clk_logic) begin
    if (alloc) begin
      fifo_addr[wr_ptr] <= wr_addr_i;
      fifo_data[wr_ptr] <= wr_data_i;
      fifo_be[wr_ptr]   <= wr_be_i;
    end
`ifdef SHADOW_ARB_MERGE_EN
    else if (merge) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (wr_be_i[b]) fifo_data[last_ptr][8*b +: 8] <= wr_data_i[8*b +: 8];
      end
      fifo_be[last_ptr] <= fifo_be[last_ptr] | wr_be_i;
    end
`endif
  end

  // FIFO pointers, occupancy, overflow flag, video request latch, FSM state
  always_ff @(posedge clk_logic or negedge system_reset_n) begin
    if (!system_reset_n) begin
      state_q    <= IDLE;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count_q    <= '0;
      overflow_o <= 1'b0;
      vid_pend   <= 1'b0;
      vid_addr_q <= '0;
    end else begin
      state_q <= state_d;
      if (alloc) wr_ptr <= wr_ptr + PW'(1);
      if (pop)   rd_ptr <= rd_ptr + PW'(1);
      count_q <= count_q + {{PW{1'b0}}, alloc} - {{PW{1'b0}}, pop};
      if (wr_strobe_i && !merge && !alloc) overflow_o <= 1'b1;
      // A same-cycle request wins over the clear on read accept.
      if (vid_rd_i) begin
        vid_pend   <= 1'b1;
        vid_addr_q <= vid_addr_i;
      end else if (rd_ack) begin
        vid_pend <= 1'b0;
      end
    end
  end

  // Registered command and video-return outputs
  always_ff @(posedge clk_logic or negedge system_reset_n) begin
    if (!system_reset_n) begin
      mem_rd_o    <= 1'b0;
      mem_wr_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_data_o  <= '0;
      mem_be_o    <= '0;
      vid_data_o  <= '0;
      vid_valid_o <= 1'b0;
    end else begin
      vid_valid_o <= 1'b0;
      if (pick_wr) begin
        mem_wr_o   <= 1'b1;
        mem_addr_o <= fifo_addr[rd_ptr];
        mem_data_o <= fifo_data[rd_ptr];
        mem_be_o   <= fifo_be[rd_ptr];
      end else if (pick_rd) begin
        mem_rd_o   <= 1'b1;
        mem_addr_o <= vid_addr_q;
        mem_data_o <= '0;
        mem_be_o   <= '1;
      end
      if (pop)    mem_wr_o <= 1'b0;
      if (rd_ack) mem_rd_o <= 1'b0;
      if ((state_q == READ_WAIT) && mem_rvalid_i) begin
        vid_data_o  <= mem_q_i;
        vid_valid_o <= 1'b1;
      end
    end
  end

  assign fifo_count_o = count_q;

endmodule

// File: tb/tb_shadow_mem_arbiter.sv
// Directed testbench for shadow_mem_arbiter (default parameters 8/6/21).
module tb_shadow_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        wr_strobe;
  logic [20:0] wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic        vid_rd;
  logic [20:0] vid_addr;
  logic [31:0] vid_data;
  logic        vid_valid;
  logic        mem_rd;
  logic        mem_wr;
  logic [20:0] mem_addr;
  logic [31:0] mem_data;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_q;
  logic        mem_rvalid;
  logic [3:0]  fifo_count;
  logic        overflow;

  int n_tests = 0;
  int n_fail  = 0;

  shadow_mem_arbiter #(
    .FIFO_DEPTH(8),
    .HIGH_WATER(6),
    .ADDR_WIDTH(21)
  ) dut (
    .clk_logic     (clk),
    .system_reset_n(rst_n),
    .wr_strobe_i   (wr_strobe),
    .wr_addr_i     (wr_addr),
    .wr_data_i     (wr_data),
    .wr_be_i       (wr_be),
    .vid_rd_i      (vid_rd),
    .vid_addr_i    (vid_addr),
    .vid_data_o    (vid_data),
    .vid_valid_o   (vid_valid),
    .mem_rd_o      (mem_rd),
    .mem_wr_o      (mem_wr),
    .mem_addr_o    (mem_addr),
    .mem_data_o    (mem_data),
    .mem_be_o      (mem_be),
    .mem_ack_i     (mem_ack),
    .mem_q_i       (mem_q),
    .mem_rvalid_i  (mem_rvalid),
    .fifo_count_o  (fifo_count),
    .overflow_o    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [20:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_strobe = 1'b1;
    wr_addr   = a;
    wr_data   = d;
    wr_be     = be;
    tick();
    wr_strobe = 1'b0;
  endtask

  task automatic ack_cmd;
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; wr_strobe = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
    vid_rd = 1'b0; vid_addr = '0; mem_ack = 1'b0; mem_q = '0; mem_rvalid = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_wr",   64'(mem_wr),     64'd0);
    chk("rst_mem_rd",   64'(mem_rd),     64'd0);
    chk("rst_mem_addr", 64'(mem_addr),   64'd0);
    chk("rst_mem_data", 64'(mem_data),   64'd0);
    chk("rst_mem_be",   64'(mem_be),     64'd0);
    chk("rst_vid_val",  64'(vid_valid),  64'd0);
    chk("rst_vid_data", 64'(vid_data),   64'd0);
    chk("rst_count",    64'(fifo_count), 64'd0);
    chk("rst_ovf",      64'(overflow),   64'd0);
    rst_n = 1'b1;
    repeat (3) tick();
    chk("idle_mem_wr", 64'(mem_wr),     64'd0);
    chk("idle_mem_rd", 64'(mem_rd),     64'd0);
    chk("idle_count",  64'(fifo_count), 64'd0);

    // Single write, acked after three cycles
    push(21'h00200, 32'hA5A5A5A5, 4'b0010);
    chk("w1_count1", 64'(fifo_count), 64'd1);
    chk("w1_not_yet", 64'(mem_wr), 64'd0);
    tick();
    chk("w1_mem_wr", 64'(mem_wr),   64'd1);
    chk("w1_mem_rd", 64'(mem_rd),   64'd0);
    chk("w1_addr",   64'(mem_addr), 64'h200);
    chk("w1_data",   64'(mem_data), 64'hA5A5A5A5);
    chk("w1_be",     64'(mem_be),   64'h2);
    tick();
    tick();
    chk("w1_hold_wr",   64'(mem_wr),   64'd1);
    chk("w1_hold_addr", 64'(mem_addr), 64'h200);
    ack_cmd();
    chk("w1_drop_wr", 64'(mem_wr),     64'd0);
    chk("w1_count0",  64'(fifo_count), 64'd0);
    tick();
    chk("w1_no_more", 64'(mem_wr), 64'd0);

    // Two writes queued, video read pending: read goes first
    wr_strobe = 1'b1; wr_addr = 21'h00400; wr_data = 32'h11111111; wr_be = 4'hF;
    vid_rd = 1'b1; vid_addr = 21'h01000;
    tick();
    vid_rd = 1'b0;
    wr_addr = 21'h00401; wr_data = 32'h22222222;
    tick();
    wr_strobe = 1'b0;
    chk("rd_mem_rd", 64'(mem_rd),     64'd1);
    chk("rd_mem_wr", 64'(mem_wr),     64'd0);
    chk("rd_addr",   64'(mem_addr),   64'h1000);
    chk("rd_be",     64'(mem_be),     64'hF);
    chk("rd_count2", 64'(fifo_count), 64'd2);
    ack_cmd();
    chk("rd_drop", 64'(mem_rd), 64'd0);
    tick();
    chk("rd_wait_no_wr", 64'(mem_wr), 64'd0);
    mem_rvalid = 1'b1; mem_q = 32'hDEADBEEF;
    tick();
    mem_rvalid = 1'b0;
    chk("rd_valid", 64'(vid_valid), 64'd1);
    chk("rd_data",  64'(vid_data),  64'hDEADBEEF);
    tick();
    chk("rd_valid_pulse", 64'(vid_valid), 64'd0);
    chk("drain1_wr",   64'(mem_wr),   64'd1);
    chk("drain1_addr", 64'(mem_addr), 64'h400);
    chk("drain1_data", 64'(mem_data), 64'h11111111);
    ack_cmd();
    chk("drain1_count", 64'(fifo_count), 64'd1);
    tick();
    chk("drain2_wr",   64'(mem_wr),   64'd1);
    chk("drain2_addr", 64'(mem_addr), 64'h401);
    ack_cmd();
    chk("drain2_count", 64'(fifo_count), 64'd0);

    // High-water: six writes queued with a video read pending
    for (int unsigned i = 0; i < 6; i++) begin
      wr_strobe = 1'b1; wr_addr = 21'h00500 + 21'(i); wr_data = 32'(i); wr_be = 4'hF;
      if (i == 5) begin
        vid_rd = 1'b1; vid_addr = 21'h02000;
      end
      tick();
    end
    wr_strobe = 1'b0; vid_rd = 1'b0;
    chk("hw_count6", 64'(fifo_count), 64'd6);
    chk("hw_w0_wr",  64'(mem_wr),     64'd1);
    chk("hw_w0_addr", 64'(mem_addr),  64'h500);
    // pop with simultaneous push keeps the count at the high-water mark
    mem_ack = 1'b1;
    wr_strobe = 1'b1; wr_addr = 21'h00506; wr_data = 32'd6; wr_be = 4'hF;
    tick();
    mem_ack = 1'b0; wr_strobe = 1'b0;
    chk("hw_pushpop_count", 64'(fifo_count), 64'd6);
    tick();
    chk("hw_w1_wr",   64'(mem_wr),   64'd1);
    chk("hw_w1_rd",   64'(mem_rd),   64'd0);
    chk("hw_w1_addr", 64'(mem_addr), 64'h501);
    ack_cmd();
    chk("hw_count5", 64'(fifo_count), 64'd5);
    tick();
    chk("hw_rd",      64'(mem_rd),   64'd1);
    chk("hw_rd_addr", 64'(mem_addr), 64'h2000);
    ack_cmd();
    mem_rvalid = 1'b1; mem_q = 32'hCAFEF00D;
    tick();
    mem_rvalid = 1'b0;
    chk("hw_rd_valid", 64'(vid_valid), 64'd1);
    chk("hw_rd_data",  64'(vid_data),  64'hCAFEF00D);
    for (int unsigned i = 2; i < 7; i++) begin
      tick();
      chk("hw_drain_wr",   64'(mem_wr),   64'd1);
      chk("hw_drain_addr", 64'(mem_addr), 64'h500 + 64'(i));
      chk("hw_drain_data", 64'(mem_data), 64'(i));
      ack_cmd();
    end
    chk("hw_count0", 64'(fifo_count), 64'd0);

    // Overflow: nine writes, no ack
    for (int unsigned i = 0; i < 8; i++) begin
      push(21'h00600 + 21'(i), 32'(i), 4'hF);
    end
    chk("ovf_count8", 64'(fifo_count), 64'd8);
    chk("ovf_clear",  64'(overflow),   64'd0);
    push(21'h00608, 32'd8, 4'hF);
    chk("ovf_count_stays", 64'(fifo_count), 64'd8);
    chk("ovf_set",         64'(overflow),   64'd1);
    tick();
    tick();
    chk("ovf_sticky",   64'(overflow), 64'd1);
    chk("ovf_head_wr",  64'(mem_wr),   64'd1);
    chk("ovf_head_adr", 64'(mem_addr), 64'h600);
    mem_ack = 1'b1;
    wr_strobe = 1'b1; wr_addr = 21'h006FF; wr_data = 32'hFF; wr_be = 4'hF;
    tick();
    mem_ack = 1'b0; wr_strobe = 1'b0;
    chk("full_pushpop_count", 64'(fifo_count), 64'd8);
    chk("full_pushpop_ovf",   64'(overflow),   64'd1);
    tick();
    chk("ovf_next_wr",   64'(mem_wr),   64'd1);
    chk("ovf_next_addr", 64'(mem_addr), 64'h601);

    // Asynchronous reset mid-WRITE_CMD
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_mem_wr",   64'(mem_wr),     64'd0);
    chk("arst_mem_addr", 64'(mem_addr),   64'd0);
    chk("arst_mem_data", 64'(mem_data),   64'd0);
    chk("arst_mem_be",   64'(mem_be),     64'd0);
    chk("arst_count",    64'(fifo_count), 64'd0);
    chk("arst_ovf",      64'(overflow),   64'd0);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("arst_idle_wr",    64'(mem_wr),     64'd0);
    chk("arst_idle_count", 64'(fifo_count), 64'd0);

    // Same-address writes behind a busy head
    push(21'h00700, 32'h77777777, 4'hF);
    push(21'h00300, 32'h00000011, 4'b0001);
    push(21'h00300, 32'h00330000, 4'b0100);
`ifdef SHADOW_ARB_MERGE_EN
    chk("mrg_count", 64'(fifo_count), 64'd2);
`else
    chk("nomrg_count", 64'(fifo_count), 64'd3);
`endif
    chk("mrg_head_addr", 64'(mem_addr), 64'h700);
    ack_cmd();
    tick();
    chk("mrg_wr",   64'(mem_wr),   64'd1);
    chk("mrg_addr", 64'(mem_addr), 64'h300);
`ifdef SHADOW_ARB_MERGE_EN
    chk("mrg_count1", 64'(fifo_count), 64'd1);
    chk("mrg_be",     64'(mem_be),     64'h5);
    chk("mrg_data",   64'(mem_data),   64'h00330011);
    ack_cmd();
`else
    chk("nomrg_count2", 64'(fifo_count), 64'd2);
    chk("nomrg_be1",    64'(mem_be),     64'h1);
    chk("nomrg_data1",  64'(mem_data),   64'h00000011);
    ack_cmd();
    tick();
    chk("nomrg_addr2",  64'(mem_addr),   64'h300);
    chk("nomrg_be2",    64'(mem_be),     64'h4);
    chk("nomrg_data2",  64'(mem_data),   64'h00330000);
    ack_cmd();
`endif
    chk("mrg_final_count", 64'(fifo_count), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
